deadtime_comp: RTL and testbench

- Sits directly downstream of the per-leg PWM comparator.
- Takes the single-ended switching command S_in and produces the complementary upper/lower gate signals Sa/Sb for one inverter half-bridge.
- Inserts a configurable dead time, in clk cycles, before either switch turns on.
- Forces both gates off when the leg is disabled.

---
 rtl/deadtime_comp.sv | 122 ++++++++++++
 tb/tb_deadtime_comp.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/deadtime_comp.sv
// Dead-time generator for one inverter half-bridge leg: S_in -> complementary Sa/Sb gates.
// Latency: 1 clk from S_in to the falling gate, 1 + deadtime clk to the rising gate.
// Backpressure: none; a free-running gate driver that follows S_in/en every cycle.
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   en         - leg enable; 0 forces both gates off on the next edge
//   S_in       - PWM command, 1 = upper switch on
//   deadtime   - both-off interval in clk cycles (0 = none), sampled when an interval starts
//   Sa, Sb     - registered upper/lower gate drives, never both 1
//   dt_active  - registered, high while a dead-time interval is running
module deadtime_comp #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                S_in,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                Sa,
  output logic                Sb,
  output logic                dt_active
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    DT_HI = 3'd3,
    DT_LO = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_nxt;
  logic                dt_zero;

  assign dt_zero = (deadtime == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      // Counter deliberately frozen; it is reloaded on the next interval anyway.
      state_nxt = OFF;
    end else begin
      case (state)
        OFF: begin
          if (dt_zero) begin
            state_nxt = S_in ? HI : LO;
          end else begin
            state_nxt = S_in ? DT_HI : DT_LO;
            cnt_nxt   = deadtime;
          end
        end
        HI: begin
          if (!S_in) begin
            if (dt_zero) begin
              state_nxt = LO;
            end else begin
              state_nxt = DT_LO;
              cnt_nxt   = deadtime;
            end
          end
        end
        LO: begin
          if (S_in) begin
            if (dt_zero) begin
              state_nxt = HI;
            end else begin
              state_nxt = DT_HI;
              cnt_nxt   = deadtime;
            end
          end
        end
        DT_HI: begin
          // A reverted command returns straight to LO: Sa never turned on,
          // so the lower switch can safely resume without a gap.
          if (!S_in) begin
            state_nxt = LO;
          end else if (cnt <= DT_WIDTH'(1)) begin
            state_nxt = HI;
          end else begin
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        DT_LO: begin
          if (S_in) begin
            state_nxt = HI;
          end else if (cnt <= DT_WIDTH'(1)) begin
            state_nxt = LO;
          end else begin
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state_nxt = OFF;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each gate changes on the
  // same edge as the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OFF;
      cnt       <= '0;
      Sa        <= 1'b0;
      Sb        <= 1'b0;
      dt_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Sa        <= (state_nxt == HI);
      Sb        <= (state_nxt == LO);
      dt_active <= (state_nxt == DT_HI) || (state_nxt == DT_LO);
    end
  end

endmodule

// File: tb/tb_deadtime_comp.sv
// Bench for deadtime_comp: directed vectors with hand-computed {Sa,Sb,dt_active}
// pushed to a scoreboard queue, plus a randomised run checking gate invariants.
module tb_deadtime_comp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       S_in = 1'b0;
  logic [7:0] deadtime = 8'd0;
  logic       Sa;
  logic       Sb;
  logic       dt_active;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0] exp_q[$];
  string      name_q[$];

  deadtime_comp #(.DT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .S_in      (S_in),
    .deadtime  (deadtime),
    .Sa        (Sa),
    .Sb        (Sb),
    .dt_active (dt_active)
  );

  always #5 clk = ~clk;

  // Drive n cycles of one input vector; each cycle expects {Sa,Sb,dt_active}=x
  // after the following rising edge.
  task automatic step(input int n, input logic r, input logic e, input logic s,
                      input logic [7:0] d, input logic [2:0] x, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; en = e; S_in = s; deadtime = d;
      exp_q.push_back(x);
      name_q.push_back(nm);
    end
  endtask

  // Monitor: scoreboard pops plus invariant / dead-gap tracking.
  int         prev_gate = 0;
  int         last_gate = 0;
  logic       prev_dt = 1'b0;
  int         dt_len = 0;
  int         dt_req = 0;

  initial begin
    logic [2:0] got;
    logic [2:0] want;
    string      nm;
    int         cur_gate;
    forever begin
      @(posedge clk);
      #1;
      got = {Sa, Sb, dt_active};
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got Sa/Sb/dt=%b want %b at %0t", nm, got, want, $time);
      end

      n_chk++;
      if (!(Sa === 1'b1 && Sb === 1'b1)) n_pass++;
      else $display("FAIL shoot_through: Sa=%b Sb=%b want not both 1 at %0t", Sa, Sb, $time);

      cur_gate = Sa ? 1 : (Sb ? 2 : 0);
      if (dt_active && !prev_dt) begin
        dt_req = int'(deadtime);
        dt_len = 0;
      end
      if (dt_active) dt_len++;
      if (cur_gate != 0 && prev_gate == 0 && prev_dt && last_gate != 0 && cur_gate != last_gate) begin
        n_chk++;
        if (dt_len >= dt_req) n_pass++;
        else $display("FAIL dead_gap: both-off %0d cycles, want >= %0d at %0t", dt_len, dt_req, $time);
      end
      if (cur_gate != 0) last_gate = cur_gate;
      else if (!dt_active) last_gate = 0;
      prev_gate = cur_gate;
      prev_dt   = dt_active;
    end
  end

  initial begin
    int hold;
    int cyc;
    // Reset
    step(2, 1, 0, 0, 8'd5, 3'b000, "reset");
    // Enable with deadtime 5: gates off 5 cycles, then Sb
    step(5, 0, 1, 0, 8'd5, 3'b001, "enable_dt");
    step(3, 0, 1, 0, 8'd5, 3'b010, "lo_after_enable");
    // LO -> HI with 5-cycle dead time
    step(5, 0, 1, 1, 8'd5, 3'b001, "lo_hi_dt");
    step(2, 0, 1, 1, 8'd5, 3'b100, "hi_after_dt");
    // Maximum dead time 255
    step(255, 0, 1, 0, 8'd255, 3'b001, "max_dt");
    step(1, 0, 1, 0, 8'd255, 3'b010, "max_dt_lo");
    // Zero dead time: direct swaps
    step(3, 0, 1, 1, 8'd0, 3'b100, "zero_dt_hi");
    step(3, 0, 1, 0, 8'd0, 3'b010, "zero_dt_lo");
    step(1, 0, 1, 1, 8'd0, 3'b100, "zero_dt_hi2");
    step(1, 0, 1, 0, 8'd0, 3'b010, "zero_dt_lo2");
    // Short pulse absorbed: Sa never asserts
    step(3, 0, 1, 1, 8'd8, 3'b001, "short_pulse_dt");
    step(2, 0, 1, 0, 8'd8, 3'b010, "short_pulse_resume");
    // Disable / re-enable
    step(4, 0, 1, 1, 8'd4, 3'b001, "to_hi_dt4");
    step(2, 0, 1, 1, 8'd4, 3'b100, "hi_dt4");
    step(3, 0, 0, 1, 8'd4, 3'b000, "disabled");
    step(4, 0, 1, 1, 8'd4, 3'b001, "reenable_dt");
    step(1, 0, 1, 1, 8'd4, 3'b100, "reenable_hi");
    // deadtime change mid-interval keeps the loaded count
    step(1, 0, 1, 0, 8'd0, 3'b010, "mid_to_lo");
    step(4, 0, 1, 1, 8'd6, 3'b001, "mid_dt6");
    step(2, 0, 1, 1, 8'd2, 3'b001, "mid_dt6_cont");
    step(1, 0, 1, 1, 8'd2, 3'b100, "mid_hi");
    step(2, 0, 1, 0, 8'd2, 3'b001, "next_dt2");
    step(1, 0, 1, 0, 8'd2, 3'b010, "next_lo");
    // Reset in the middle of DT_LO
    step(1, 0, 1, 1, 8'd0, 3'b100, "pre_rst_hi");
    step(2, 0, 1, 0, 8'd6, 3'b001, "pre_rst_dt");
    step(1, 1, 1, 0, 8'd6, 3'b000, "rst_mid_dt");
    step(1, 0, 0, 0, 8'd6, 3'b000, "post_rst_off");
    // deadtime = 1 boundary
    step(1, 0, 1, 1, 8'd1, 3'b001, "dt1_enable");
    step(1, 0, 1, 1, 8'd1, 3'b100, "dt1_hi");
    step(1, 0, 1, 0, 8'd1, 3'b001, "dt1_swap");
    step(1, 0, 1, 0, 8'd1, 3'b010, "dt1_lo");

    // Random run: invariants only
    cyc = 0;
    while (cyc < 10000) begin
      hold = $urandom_range(1, 12);
      @(negedge clk);
      rst      = ($urandom_range(0, 63) == 0);
      en       = ($urandom_range(0, 7) != 0);
      S_in     = 1'($urandom_range(0, 1));
      deadtime = 8'($urandom_range(0, 7));
      cyc++;
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        rst = 1'b0;
        cyc++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
